// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and latency constants for the hazard controller
package hazard_pkg;
  typedef enum logic {RUN, BUSY} mdu_state_e;
  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;
  localparam int CNT_W = $clog2(DIV_LAT_DEF > MUL_LAT_DEF ? DIV_LAT_DEF : MUL_LAT_DEF) + 1;
  function automatic logic src_hit(input logic [4:0] r, input logic use_r, input logic [4:0] w);
    return use_r && r != 5'd0 && r == w;
  endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: hazard inputs from the pipeline and we/flush controls back to it
interface hazard_ctrl_if;
  logic ext_stall;
  logic [4:0] id_rs, id_rt, ex_wreg, mem_wreg;
  logic id_use_rs, id_use_rt, id_branch, br_taken;
  logic ex_regwrite, ex_mem_read, mem_mem_read;
  logic id_mdu_op, mdu_start, mdu_is_div;
  logic pc_we, ifid_we, ifid_flush, idex_we, idex_flush;
  logic exmem_we, exmem_flush, memwb_we, memwb_flush, mdu_busy;
  modport master (
    input ext_stall, id_rs, id_rt, id_use_rs, id_use_rt, id_branch, br_taken,
          ex_wreg, ex_regwrite, ex_mem_read, mem_wreg, mem_mem_read,
          id_mdu_op, mdu_start, mdu_is_div,
    output pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
           exmem_we, exmem_flush, memwb_we, memwb_flush, mdu_busy
  );
  modport slave (
    output ext_stall, id_rs, id_rt, id_use_rs, id_use_rt, id_branch, br_taken,
           ex_wreg, ex_regwrite, ex_mem_read, mem_wreg, mem_mem_read,
           id_mdu_op, mdu_start, mdu_is_div,
    input pc_we, ifid_we, ifid_flush, idex_we, idex_flush,
          exmem_we, exmem_flush, memwb_we, memwb_flush, mdu_busy
  );
endinterface

// File: rtl/mdu_stall_timer.sv
// mdu_stall_timer: counts multiply/divide busy cycles after an issue
module mdu_stall_timer
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic is_div,
  output logic busy
);
  mdu_state_e state, nstate;
  logic [CNT_W-1:0] cnt, ncnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt <= '0;
    end else begin
      state <= nstate;
      cnt <= ncnt;
    end
  end
  always_comb begin
    nstate = state;
    ncnt = cnt;
    if (state == RUN && start) begin
      nstate = BUSY;
      ncnt = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
    end else if (state == BUSY) begin
      nstate = cnt == CNT_W'(1) ? RUN : BUSY;
      ncnt = cnt == CNT_W'(1) ? '0 : cnt - CNT_W'(1);
    end
  end
  assign busy = state == BUSY;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush controller; MDU tracking enabled by HAZARD_MDU_EN
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input logic clk,
  input logic rst,
  hazard_ctrl_if.master hz
);
  logic busy, mdu_hazard, load_use, br_hazard, hz_stall, ex_hit, mem_hit, run;
`ifdef HAZARD_MDU_EN
  mdu_stall_timer #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) u_mdu (
    .clk(clk),
    .rst(rst),
    .start(hz.mdu_start),
    .is_div(hz.mdu_is_div),
    .busy(busy)
  );
  assign mdu_hazard = hz.id_mdu_op & busy;
`else
  logic unused_mdu;
  assign unused_mdu = ^{clk, hz.id_mdu_op, hz.mdu_start, hz.mdu_is_div, MUL_LAT[0], DIV_LAT[0]};
  assign busy = 1'b0;
  assign mdu_hazard = 1'b0;
`endif
  assign ex_hit = src_hit(hz.id_rs, hz.id_use_rs, hz.ex_wreg) | src_hit(hz.id_rt, hz.id_use_rt, hz.ex_wreg);
  assign mem_hit = src_hit(hz.id_rs, hz.id_use_rs, hz.mem_wreg) | src_hit(hz.id_rt, hz.id_use_rt, hz.mem_wreg);
  assign load_use = hz.ex_mem_read & ex_hit;
  assign br_hazard = hz.id_branch & ((hz.ex_regwrite & ex_hit) | (hz.mem_mem_read & mem_hit));
  assign hz_stall = load_use | br_hazard | mdu_hazard;
  // A taken branch under a stall saw stale operands, so it must not flush IF/ID.
  assign run = ~hz.ext_stall;
  assign hz.pc_we = rst | (run & ~hz_stall);
  assign hz.ifid_we = rst | (run & ~hz_stall);
  assign hz.ifid_flush = rst | (run & ~hz_stall & hz.br_taken);
  assign hz.idex_we = rst | run;
  assign hz.idex_flush = rst | (run & hz_stall);
  assign hz.exmem_we = rst | run;
  assign hz.exmem_flush = rst;
  assign hz.memwb_we = rst | run;
  assign hz.memwb_flush = rst;
  assign hz.mdu_busy = busy;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus random stimulus against a behavioural model
module tb_hazard_ctrl;
`ifdef HAZARD_MDU_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif
  localparam logic [8:0] V_ALL = 9'b111_11_11_11;
  localparam logic [8:0] V_FRZ = 9'b000_00_00_00;
  localparam logic [8:0] V_STL = 9'b000_11_10_10;
  localparam logic [8:0] V_BRT = 9'b111_10_10_10;
  localparam logic [8:0] V_RUN = 9'b110_10_10_10;
  logic clk = 1'b0;
  logic rst;
  int errors = 0;
  int checks = 0;
  int busy_left = 0;
  logic [8:0] act;
  hazard_ctrl_if hz();
  hazard_ctrl dut (.clk(clk), .rst(rst), .hz(hz.master));
  always #5 clk = ~clk;
  assign act = {hz.pc_we, hz.ifid_we, hz.ifid_flush, hz.idex_we, hz.idex_flush,
                hz.exmem_we, hz.exmem_flush, hz.memwb_we, hz.memwb_flush};
  // remaining busy cycles of the multiply/divide unit
  always @(posedge clk) begin
    if (rst) busy_left = 0;
    else if (busy_left > 0) busy_left = busy_left - 1;
    else if (MDU_EN && hz.mdu_start) busy_left = hz.mdu_is_div ? 10 : 5;
  end
  function automatic bit hit(input logic [4:0] r, input logic u, input logic [4:0] w);
    return u && r != 0 && r == w;
  endfunction
  function automatic logic [8:0] model_ctrl();
    bit exh, memh, stall;
    exh = hit(hz.id_rs, hz.id_use_rs, hz.ex_wreg) || hit(hz.id_rt, hz.id_use_rt, hz.ex_wreg);
    memh = hit(hz.id_rs, hz.id_use_rs, hz.mem_wreg) || hit(hz.id_rt, hz.id_use_rt, hz.mem_wreg);
    stall = (hz.ex_mem_read && exh) || (hz.id_branch && ((hz.ex_regwrite && exh) || (hz.mem_mem_read && memh)))
            || (hz.id_mdu_op && busy_left > 0);
    if (rst) return V_ALL;
    if (hz.ext_stall) return V_FRZ;
    if (stall) return V_STL;
    if (hz.br_taken) return V_BRT;
    return V_RUN;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs();
    hz.ext_stall = 0; hz.id_rs = 0; hz.id_rt = 0; hz.id_use_rs = 0; hz.id_use_rt = 0;
    hz.id_branch = 0; hz.br_taken = 0; hz.ex_wreg = 0; hz.ex_regwrite = 0; hz.ex_mem_read = 0;
    hz.mem_wreg = 0; hz.mem_mem_read = 0; hz.id_mdu_op = 0; hz.mdu_start = 0; hz.mdu_is_div = 0;
  endtask
  task automatic test_reset();
    clear_inputs();
    rst = 1;
    tick();
    @(negedge clk);
    checks++;
    if (act !== V_ALL) begin errors++; $display("FAIL reset_ctrl got=%b want=%b", act, V_ALL); end
    checks++;
    if (hz.mdu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", hz.mdu_busy); end
    tick();
    rst = 0;
    @(negedge clk);
    checks++;
    if (act !== V_RUN) begin errors++; $display("FAIL idle_ctrl got=%b want=%b", act, V_RUN); end
    tick();
  endtask
  task automatic test_load_use();
    hz.ex_mem_read = 1; hz.ex_wreg = 8; hz.id_rs = 8; hz.id_use_rs = 1;
    @(negedge clk);
    checks++;
    if (act !== V_STL) begin errors++; $display("FAIL load_use_stall got=%b want=%b", act, V_STL); end
    tick();
    hz.ex_mem_read = 0; hz.ex_wreg = 0; hz.mem_wreg = 8;
    @(negedge clk);
    checks++;
    if (act !== V_RUN) begin errors++; $display("FAIL load_use_release got=%b want=%b", act, V_RUN); end
    tick();
    clear_inputs();
  endtask
  task automatic test_zero_reg();
    hz.ex_mem_read = 1; hz.ex_wreg = 0; hz.id_rs = 0; hz.id_use_rs = 1;
    @(negedge clk);
    checks++;
    if (act !== V_RUN) begin errors++; $display("FAIL zero_reg got=%b want=%b", act, V_RUN); end
    hz.id_rt = 8; hz.ex_wreg = 8;
    @(negedge clk);
    checks++;
    if (act !== V_RUN) begin errors++; $display("FAIL rt_unused got=%b want=%b", act, V_RUN); end
    tick();
    clear_inputs();
  endtask
  task automatic test_branch();
    hz.id_branch = 1; hz.br_taken = 1; hz.ex_regwrite = 1; hz.ex_wreg = 9; hz.id_rt = 9; hz.id_use_rt = 1;
    @(negedge clk);
    checks++;
    if (act !== V_STL) begin errors++; $display("FAIL branch_stale got=%b want=%b", act, V_STL); end
    tick();
    hz.ex_regwrite = 0; hz.ex_wreg = 0; hz.mem_wreg = 9;
    @(negedge clk);
    checks++;
    if (act !== V_BRT) begin errors++; $display("FAIL branch_taken got=%b want=%b", act, V_BRT); end
    tick();
    hz.ex_mem_read = 1; hz.ex_regwrite = 1; hz.ex_wreg = 9; hz.mem_wreg = 0;
    @(negedge clk);
    checks++;
    if (act !== V_STL) begin errors++; $display("FAIL branch_load_ex got=%b want=%b", act, V_STL); end
    tick();
    hz.ex_mem_read = 0; hz.ex_regwrite = 0; hz.ex_wreg = 0; hz.mem_mem_read = 1; hz.mem_wreg = 9;
    @(negedge clk);
    checks++;
    if (act !== V_STL) begin errors++; $display("FAIL branch_load_mem got=%b want=%b", act, V_STL); end
    tick();
    clear_inputs();
  endtask
  task automatic test_mdu(input bit is_div);
    int lat;
    lat = is_div ? 10 : 5;
    hz.mdu_start = 1; hz.mdu_is_div = is_div;
    tick();
    hz.mdu_start = 0; hz.mdu_is_div = 0; hz.id_mdu_op = 1;
    for (int k = 1; k <= lat + 1; k++) begin
      logic eb;
      logic [8:0] ec;
      eb = MDU_EN && k <= lat;
      ec = eb ? V_STL : V_RUN;
      @(negedge clk);
      checks++;
      if (hz.mdu_busy !== eb) begin errors++; $display("FAIL mdu_busy div=%0d k=%0d got=%b want=%b", is_div, k, hz.mdu_busy, eb); end
      checks++;
      if (act !== ec) begin errors++; $display("FAIL mdu_stall div=%0d k=%0d got=%b want=%b", is_div, k, act, ec); end
      tick();
    end
    clear_inputs();
  endtask
  task automatic test_priority();
    hz.ext_stall = 1; hz.ex_mem_read = 1; hz.ex_wreg = 8; hz.id_rs = 8; hz.id_use_rs = 1; hz.br_taken = 1;
    @(negedge clk);
    checks++;
    if (act !== V_FRZ) begin errors++; $display("FAIL ext_stall_prio got=%b want=%b", act, V_FRZ); end
    tick();
    clear_inputs();
    hz.mdu_start = 1; hz.mdu_is_div = 1;
    tick();
    clear_inputs();
    hz.ext_stall = 1;
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (hz.mdu_busy !== MDU_EN) begin errors++; $display("FAIL busy_in_freeze got=%b want=%b", hz.mdu_busy, MDU_EN); end
    rst = 1;
    @(negedge clk);
    checks++;
    if (act !== V_ALL) begin errors++; $display("FAIL reset_prio got=%b want=%b", act, V_ALL); end
    tick();
    rst = 0; hz.ext_stall = 0;
    @(negedge clk);
    checks++;
    if (hz.mdu_busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy got=%b want=0", hz.mdu_busy); end
    tick();
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 39) == 0;
      hz.ext_stall = $urandom_range(0, 7) == 0;
      hz.id_rs = 5'($urandom_range(0, 3)); hz.id_rt = 5'($urandom_range(0, 3));
      hz.id_use_rs = 1'($urandom); hz.id_use_rt = 1'($urandom);
      hz.id_branch = 1'($urandom); hz.br_taken = 1'($urandom);
      hz.ex_wreg = 5'($urandom_range(0, 3)); hz.ex_regwrite = 1'($urandom); hz.ex_mem_read = 1'($urandom);
      hz.mem_wreg = 5'($urandom_range(0, 3)); hz.mem_mem_read = 1'($urandom);
      hz.id_mdu_op = 1'($urandom); hz.mdu_start = $urandom_range(0, 5) == 0; hz.mdu_is_div = 1'($urandom);
      @(negedge clk);
      checks++;
      if (act !== model_ctrl()) begin errors++; $display("FAIL rand_ctrl i=%0d got=%b want=%b", i, act, model_ctrl()); end
      checks++;
      if (hz.mdu_busy !== (busy_left > 0)) begin errors++; $display("FAIL rand_busy i=%0d got=%b want=%b", i, hz.mdu_busy, busy_left > 0); end
      tick();
    end
    rst = 0;
    clear_inputs();
  endtask
  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch();
    test_mdu(1'b1);
    test_mdu(1'b0);
    test_priority();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller that drives the write-enable and flush inputs of every inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC. It detects load-use and branch-operand hazards on 5-bit register addresses, tracks a multi-cycle multiply/divide unit, and honours an external freeze request. It is the producing end of the `we`/`flush` interface that the pipeline registers consume.

## Interface
Parameters:
- `MUL_LAT`, default 5: multiply busy cycles.
- `DIV_LAT`, default 10: divide busy cycles.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ext_stall` in 1: external freeze request, e.g. memory wait.
- `id_rs`, `id_rt` in 5 each: source register addresses in ID.
- `id_use_rs`, `id_use_rt` in 1 each: the ID instruction reads rs/rt.
- `id_branch` in 1: ID holds a branch resolved in ID.
- `br_taken` in 1: branch in ID is taken.
- `ex_wreg` in 5: destination register in EX.
- `ex_regwrite`, `ex_mem_read` in 1 each: EX writes a register / EX is a load.
- `mem_wreg` in 5: destination register in MEM.
- `mem_mem_read` in 1: MEM is a load.
- `id_mdu_op` in 1: ID holds mult/div/mfhi/mflo/mthi/mtlo.
- `mdu_start` in 1: mult/div issues from EX this cycle.
- `mdu_is_div` in 1: the issuing op is a divide.
- `pc_we` out 1: PC write enable.
- `ifid_we`, `ifid_flush` out 1 each: IF/ID register controls.
- `idex_we`, `idex_flush` out 1 each: ID/EX register controls.
- `exmem_we`, `exmem_flush` out 1 each: EX/MEM register controls.
- `memwb_we`, `memwb_flush` out 1 each: MEM/WB register controls.
- `mdu_busy` out 1: MDU result not yet available (registered).

## Operation
- Register-side rule: flush takes effect only when the matching `we` is 1. A bubble is therefore `we=1, flush=1`. A hold is `we=0`, with flush don't-care; this block drives it as 0.
- `src_hit(r)` is true when `r != 0` and the matching `id_use_*` is set.
- `load_use`: `ex_mem_read` and `src_hit` against `ex_wreg`.
- `br_hazard`: `id_branch` and either of the following:
  - `ex_regwrite` and `src_hit` against `ex_wreg`;
  - `mem_mem_read` and `src_hit` against `mem_wreg`.
- `mdu_hazard`: `id_mdu_op` and `mdu_busy`.
- `hz_stall` = `load_use | br_hazard | mdu_hazard`.
- Output priority (highest first):
  1. `rst`: every `*_we=1`, every `*_flush=1`, `pc_we=1`. All registers clear.
  2. `ext_stall`: every `we=0`, every `flush=0`, including `pc_we=0`.
  3. `hz_stall`: `pc_we=0`, `ifid_we=0`, `idex_we=1`, `idex_flush=1`. EX/MEM and MEM/WB run normally.
  4. `br_taken` (no stall): `ifid_we=1`, `ifid_flush=1`. All other stages run.
  5. Otherwise: all `we=1`, all `flush=0`.
- `br_taken` is ignored while `hz_stall` is high, because the branch was evaluated on stale operands.
- MDU tracker state machine, states `RUN` and `BUSY`:
  - `RUN` with `mdu_start`: load `cnt` with `MDU_DIV ? DIV_LAT : MUL_LAT`, go to `BUSY`.
  - `BUSY`: `cnt` decrements each cycle. When `cnt==1`, go to `RUN` and set `cnt` to 0.
  - `mdu_start` while `BUSY` is ignored. This cannot occur legally, since `mdu_hazard` blocks issue.
  - The counter keeps running during `ext_stall`.
- `mdu_busy` = (state == `BUSY`).
- Reset mid-operation: state goes to `RUN`, `cnt` goes to 0, `mdu_busy` goes to 0 on the next edge.

## Timing
- Every stage control output is combinational from the current inputs and the registered state, with zero latency. It is valid in the same cycle and sampled by the pipeline registers at the next edge.
- Reset values: state `RUN`, `cnt=0`, `mdu_busy=0`. While `rst` is high the outputs are as given in priority level 1.
- `mdu_start` sampled at edge N ⇒ `mdu_busy` is high in cycles N+1 through N+LAT. An mfhi held in ID is released in cycle N+LAT+1.
- Load-use costs exactly 1 bubble.
- Branch hazard against an EX ALU result costs 1 bubble. Against an EX load it costs 2 bubbles: the first from EX, the second from MEM.
- `ext_stall` for k cycles freezes the pipeline for k cycles with no state loss.

## Configuration
- Macro `HAZARD_MDU_EN`.
- Defined: MDU tracker, `cnt` and `mdu_hazard` are present as described.
- Undefined:
  - No counter and no state register.
  - `mdu_busy` is tied to 0 and `mdu_hazard` is 0.
  - `id_mdu_op`, `mdu_start` and `mdu_is_div` are ignored.

## Structure
- Shared package `hazard_pkg`:
  - state enum `{RUN, BUSY}`;
  - default latency constants `MUL_LAT_DEF=5` and `DIV_LAT_DEF=10`;
  - `CNT_W` = clog2(max latency)+1.
- Sub-module `mdu_stall_timer`:
  - inputs `clk`, `rst`, `start`, `is_div`;
  - output `busy`;
  - instantiated only under `HAZARD_MDU_EN`.
- Top level holds the comparators and the priority mux.

## Test plan
1. Load-use: `ex_mem_read=1`, `ex_wreg=8`, `id_rs=8`, `id_use_rs=1` → `pc_we=0`, `ifid_we=0`, `idex_we=1`, `idex_flush=1` for exactly one cycle.
2. `$zero` immunity: same as scenario 1 with `ex_wreg=0`, `id_rs=0` → no stall, all `we=1`, all `flush=0`.
3. Branch taken and stale: `id_branch=1`, `br_taken=1`, `ex_regwrite=1`, `ex_wreg=id_rt=9` → stall, `ifid_flush=0`. Next cycle with the hazard cleared → `ifid_we=1`, `ifid_flush=1`.
4. Divide: `mdu_start=1`, `mdu_is_div=1` at edge N, then `id_mdu_op=1` held → `mdu_busy` high in cycles N+1 through N+10 with the stall active. Cycle N+11: no stall.
5. Priority: `ext_stall=1` together with a load-use and `br_taken` → all `we=0`, all `flush=0`. Reset asserted during `BUSY` → every `we=1` and every `flush=1` that cycle, `mdu_busy=0` after the edge.
6. Build without `HAZARD_MDU_EN`: scenario 4 stimulus → `mdu_busy` stays 0 and there is no stall.
